// File: rtl/ccseq_pkg.sv
// ccseq_pkg: constants shared by the ComputeCore instruction sequencer.
//   - ComputeCore INS codes
//   - bit offsets of the command fields {OP3,OP2,OP1,INS}
//   - sequencer FSM state encoding
package ccseq_pkg;

  // Command field layout
  localparam int INS_LSB = 0;
  localparam int INS_W   = 5;
  localparam int OP1_LSB = 5;
  localparam int OP2_LSB = 15;
  localparam int OP3_LSB = 25;
  localparam int OP_W    = 10;

  // ComputeCore instruction codes
  localparam logic [INS_W-1:0] INS_NOP     = 5'd0;
  localparam logic [INS_W-1:0] INS_TRNG    = 5'd18;
  localparam logic [INS_W-1:0] INS_AES_ENC = 5'd19;
  localparam logic [INS_W-1:0] INS_AES_DEC = 5'd20;
  localparam logic [INS_W-1:0] INS_PADD    = 5'd22;
  localparam logic [INS_W-1:0] INS_PSUB    = 5'd23;
  localparam logic [INS_W-1:0] INS_PMUL    = 5'd24;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CLEAR   = 3'd3,
    S_GAP     = 3'd4,
    S_CLEAR_E = 3'd5,
    S_ERR     = 3'd6
  } state_e;

endpackage

// File: rtl/ccseq_if.sv
// ccseq_if: command push channel from the host plus the ComputeCore command
// port, bundled for the sequencer.
//   cmd_in/cmd_valid/cmd_ready : host -> sequencer command push
//   core_cmd/core_we0          : sequencer -> ComputeCore command_in/command_we0
//   core_done                  : ComputeCore done_ins_computation
// Handshake: a command is transferred on every rising clk edge where
// cmd_valid and cmd_ready are both 1; cmd_ready does not depend on cmd_valid,
// and the host must hold cmd_in stable while cmd_valid is high.
// modport master: host / core environment side; modport slave: sequencer side.
interface ccseq_if #(
  parameter int CMD_W = 35
);
  logic [CMD_W-1:0] cmd_in;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] core_cmd;
  logic             core_we0;
  logic             core_done;

  modport master (
    output cmd_in, cmd_valid, core_done,
    input  cmd_ready, core_cmd, core_we0
  );

  modport slave (
    input  cmd_in, cmd_valid, core_done,
    output cmd_ready, core_cmd, core_we0
  );
endinterface

// File: rtl/ccseq_fifo.sv
// ccseq_fifo: show-ahead synchronous FIFO on distributed RAM.
//   push_i/din_i : write din_i (accepted when not full, or full with a pop)
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : empty the FIFO; wins over push and pop in the same cycle
//   dout_o       : current head entry, valid while empty_o = 0
//   full_o/empty_o/count_o : occupancy
module ccseq_fifo #(
  parameter int W        = 35,
  parameter int DEPTH_LG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [W-1:0]      din_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [W-1:0]      dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [DEPTH_LG:0] count_o
);
  localparam int DEPTH = 1 << DEPTH_LG;

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_LG-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LG-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LG:0]     count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == (DEPTH_LG+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LG'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LG'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (DEPTH_LG+1)'(1);
        2'b01:   count_d = count_q - (DEPTH_LG+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/compute_core_sequencer.sv
// compute_core_sequencer: queues ComputeCore commands and issues them one at
// a time, writing a NOP after each completion so the units reset.
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus_if (slave)   : cmd_in/cmd_valid/cmd_ready push channel,
//                      core_cmd/core_we0/core_done ComputeCore port
//   run              : level, allows pops from the FIFO
//   flush            : pulse, empties the FIFO (active instruction continues)
//   clr_err          : pulse, clears tmo_err and leaves ERR
//   busy             : FSM not in IDLE
//   tmo_err          : sticky watchdog error
//   fifo_cnt         : FIFO occupancy
//   retired          : completed-instruction count (wraps)
//   state_o          : current FSM state, for observation
module compute_core_sequencer
  import ccseq_pkg::*;
#(
  parameter int               CMD_W    = 35,
  parameter int               DEPTH_LG = 4,
  parameter int               TMO_W    = 20,
  parameter logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}},
  parameter logic [INS_W-1:0] NOP_INS  = INS_NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  ccseq_if.slave            bus_if,
  input  logic              run,
  input  logic              flush,
  input  logic              clr_err,
  output logic              busy,
  output logic              tmo_err,
  output logic [DEPTH_LG:0] fifo_cnt,
  output logic [15:0]       retired,
  output state_e            state_o
);
  localparam logic [CMD_W-1:0] NOP_CMD  = CMD_W'(NOP_INS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - TMO_W'(1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] wdog_q, wdog_d;
  logic [15:0]      retired_q, retired_d;
  logic             tmo_err_q, tmo_err_d;
  logic [CMD_W-1:0] cmd_hold_q;
  logic [CMD_W-1:0] core_cmd;
  logic             core_we0;

  logic [CMD_W-1:0] head;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic             head_is_nop;

  ccseq_fifo #(
    .W        (CMD_W),
    .DEPTH_LG (DEPTH_LG)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus_if.cmd_valid & bus_if.cmd_ready),
    .din_i   (bus_if.cmd_in),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign head_is_nop = (head[INS_LSB +: INS_W] == NOP_INS);

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    retired_d = retired_q;
    tmo_err_d = tmo_err_q;
    fifo_pop  = 1'b0;
    core_we0  = 1'b0;
    core_cmd  = cmd_hold_q;

    if (clr_err) tmo_err_d = 1'b0;

    case (state_q)
      // A stale done from the previous unit blocks the issue; a flush in the
      // same cycle would empty the FIFO under the ISSUE cycle.
      S_IDLE: begin
        if (run && !fifo_empty && !flush && !bus_if.core_done) state_d = S_ISSUE;
      end
      // A NOP head has no unit to answer it. The CLEAR write that follows is
      // the same NOP, so the head write is skipped to keep core_we0 a
      // single-cycle pulse.
      S_ISSUE: begin
        fifo_pop = 1'b1;
        wdog_d   = '0;
        if (head_is_nop) begin
          retired_d = retired_q + 16'd1;
          state_d   = S_CLEAR;
        end else begin
          core_cmd = head;
          core_we0 = 1'b1;
          state_d  = S_WAIT;
        end
      end
      // wdog_q == 0 marks the first WAIT cycle, where done still reflects the
      // command register before this write took effect.
      S_WAIT: begin
        wdog_d = wdog_q + TMO_W'(1);
        if (wdog_q != '0 && bus_if.core_done) begin
          retired_d = retired_q + 16'd1;
          state_d   = S_CLEAR;
        end else if (wdog_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = S_CLEAR_E;
        end
      end
      S_CLEAR: begin
        core_cmd = NOP_CMD;
        core_we0 = 1'b1;
        state_d  = S_GAP;
      end
      S_GAP: begin
        if (!bus_if.core_done) state_d = S_IDLE;
      end
      S_CLEAR_E: begin
        core_cmd = NOP_CMD;
        core_we0 = 1'b1;
        state_d  = S_ERR;
      end
      S_ERR: begin
        if (clr_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wdog_q     <= '0;
      retired_q  <= '0;
      tmo_err_q  <= 1'b0;
      cmd_hold_q <= NOP_CMD;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      retired_q  <= retired_d;
      tmo_err_q  <= tmo_err_d;
      cmd_hold_q <= core_cmd;
    end
  end

  assign bus_if.cmd_ready = ~fifo_full;
  assign bus_if.core_cmd  = core_cmd;
  assign bus_if.core_we0  = core_we0;
  assign busy             = (state_q != S_IDLE);
  assign tmo_err          = tmo_err_q;
  assign retired          = retired_q;
  assign state_o          = state_q;
endmodule

// File: tb/tb_compute_core_sequencer.sv
module tb_compute_core_sequencer;
  import ccseq_pkg::*;

  localparam int               W   = 35;
  localparam int               DL  = 4;
  localparam int               TW  = 20;
  localparam logic [TW-1:0]    TMO = 20'd100;
  localparam logic [W-1:0]     NOP_CMD = '0;
  localparam logic [4:0]       INS_TAB [6] = '{INS_TRNG, INS_AES_ENC, INS_AES_DEC,
                                               INS_PADD, INS_PSUB, INS_PMUL};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic flush = 1'b0;
  logic clr_err = 1'b0;
  logic          busy, tmo_err;
  logic [DL:0]   fifo_cnt;
  logic [15:0]   retired;
  state_e        state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ccseq_if #(.CMD_W(W)) bus ();

  compute_core_sequencer #(
    .CMD_W(W), .DEPTH_LG(DL), .TMO_W(TW), .TMO_MAX(TMO), .NOP_INS(INS_NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_if(bus), .run(run), .flush(flush),
    .clr_err(clr_err), .busy(busy), .tmo_err(tmo_err), .fifo_cnt(fifo_cnt),
    .retired(retired), .state_o(state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic         prev_we0 = 1'b0;
  int           last_issue = -100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- ComputeCore model ----------------
  int model_lat = 20;
  int model_stale = 0;
  bit model_never = 1'b0;
  int lat_cnt = 0;
  int hold_cnt = 0;

  initial begin
    bus.core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.core_done = 1'b0;
        lat_cnt = 0;
        hold_cnt = 0;
      end else if (bus.core_we0 && bus.core_cmd[4:0] != INS_NOP) begin
        if (!model_never) lat_cnt = model_lat;
      end else if (bus.core_we0) begin
        lat_cnt = 0;
        if (bus.core_done && model_stale > 0) hold_cnt = model_stale;
        else bus.core_done = 1'b0;
      end else begin
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) bus.core_done = 1'b1;
        end
        if (hold_cnt > 0) begin
          hold_cnt--;
          if (hold_cnt == 0) bus.core_done = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.core_we0) begin
      check("we0_single_cycle", 64'(prev_we0), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_we0 actual=0x%0h required=no_write", bus.core_cmd);
      end else begin
        mon_e = exp_q.pop_front();
        check("core_cmd", 64'(bus.core_cmd), 64'(mon_e));
      end
      if (bus.core_cmd[4:0] != INS_NOP) begin
        check("done_low_at_issue", 64'(bus.core_done), 64'd0);
        check("issue_spacing", 64'((cyc - last_issue) >= 4), 64'd1);
        last_issue = cyc;
      end
    end
    prev_we0 = bus.core_we0;
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [W-1:0] c, input bit track, input bit exp_ready);
    @(negedge clk); #1;
    bus.cmd_in = c;
    bus.cmd_valid = 1'b1;
    check("cmd_ready", 64'(bus.cmd_ready), 64'(exp_ready));
    if (bus.cmd_ready && track) begin
      if (c[4:0] != INS_NOP) exp_q.push_back(c);
      exp_q.push_back(NOP_CMD);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(busy == 1'b0 && exp_q.size() == 0) && n < budget);
    check(name, 64'(busy == 1'b0 && exp_q.size() == 0), 64'd1);
  endtask

  task automatic wait_state(input string name, input state_e st, input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (state != st && n < budget);
    check(name, 64'(state), 64'(st));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.cmd_in = '0;
    bus.cmd_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tmo_err", 64'(tmo_err), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    check("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_core_we0", 64'(bus.core_we0), 64'd0);
    check("rst_core_cmd", 64'(bus.core_cmd), 64'(NOP_CMD));
    check("rst_state", 64'(state), 64'(S_IDLE));
    @(negedge clk) rst_n = 1'b1;

    // Single PMUL, done after 20 cycles
    model_lat = 20;
    run = 1'b1;
    push_cmd({10'd0, 10'd0, 10'd0, INS_PMUL}, 1'b1, 1'b1);
    wait_idle("single_idle", 200);
    check("single_retired", 64'(retired), 64'd1);
    check("single_busy", 64'(busy), 64'd0);

    // NOP head retires without a unit answering
    push_cmd({10'd3, 10'd2, 10'd1, INS_NOP}, 1'b1, 1'b1);
    wait_idle("nop_idle", 100);
    check("nop_retired", 64'(retired), 64'd2);

    // Back-to-back: fill all 16 entries, then run
    run = 1'b0;
    model_lat = 5;
    for (int i = 0; i < 16; i++)
      push_cmd({10'(i + 7), 10'(i * 3), 10'(i), INS_TAB[i % 6]}, 1'b1, 1'b1);
    @(negedge clk); #1;
    check("full_fifo_cnt", 64'(fifo_cnt), 64'd16);
    push_cmd({10'd1, 10'd1, 10'd1, INS_PADD}, 1'b1, 1'b0);
    check("full_drop_cnt", 64'(fifo_cnt), 64'd16);
    run = 1'b1;
    wait_idle("b2b_idle", 600);
    check("b2b_retired", 64'(retired), 64'd18);
    check("b2b_fifo_cnt", 64'(fifo_cnt), 64'd0);

    // Stale done held 3 cycles after each NOP write
    run = 1'b0;
    model_stale = 3;
    push_cmd({10'd5, 10'd6, 10'd7, INS_PADD}, 1'b1, 1'b1);
    push_cmd({10'd8, 10'd9, 10'd10, INS_PSUB}, 1'b1, 1'b1);
    run = 1'b1;
    wait_idle("stale_idle", 200);
    check("stale_retired", 64'(retired), 64'd20);
    model_stale = 0;
    repeat (5) @(negedge clk);

    // Watchdog: core never answers
    run = 1'b0;
    model_never = 1'b1;
    push_cmd({10'd1, 10'd2, 10'd3, INS_AES_ENC}, 1'b1, 1'b1);
    push_cmd({10'd4, 10'd5, 10'd6, INS_AES_DEC}, 1'b1, 1'b1);
    run = 1'b1;
    wait_state("wd_enter_wait", S_WAIT, 50);
    begin
      int n = 0;
      do begin
        @(negedge clk); #1;
        n++;
      end while (!tmo_err && n < 300);
      check("wd_cycles", 64'(n), 64'd100);
    end
    check("wd_state_clear_e", 64'(state), 64'(S_CLEAR_E));
    @(negedge clk); #1;
    check("wd_state_err", 64'(state), 64'(S_ERR));
    check("wd_busy", 64'(busy), 64'd1);
    check("wd_retired", 64'(retired), 64'd20);
    repeat (10) @(negedge clk);
    #1;
    check("wd_hold_err", 64'(state), 64'(S_ERR));
    check("wd_fifo_kept", 64'(fifo_cnt), 64'd1);
    model_never = 1'b0;
    model_lat = 5;
    @(negedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    check("clr_tmo_err", 64'(tmo_err), 64'd0);
    check("clr_state_idle", 64'(state), 64'(S_IDLE));
    wait_idle("wd_resume_idle", 200);
    check("wd_resume_retired", 64'(retired), 64'd21);

    // Flush with run low, then flush racing a push
    run = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd({10'(i), 10'd0, 10'd0, INS_TRNG}, 1'b0, 1'b1);
    @(negedge clk); #1;
    check("flush_pre_cnt", 64'(fifo_cnt), 64'd5);
    pulse_flush();
    check("flush_cnt", 64'(fifo_cnt), 64'd0);
    @(negedge clk); #1;
    bus.cmd_in = {10'd9, 10'd9, 10'd9, INS_PMUL};
    bus.cmd_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    flush = 1'b0;
    check("flush_vs_push_cnt", 64'(fifo_cnt), 64'd0);
    run = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("flush_no_issue", 64'(busy), 64'd0);

    // run dropped while an instruction waits
    run = 1'b0;
    model_lat = 20;
    push_cmd({10'd1, 10'd1, 10'd1, INS_PMUL}, 1'b1, 1'b1);
    push_cmd({10'd2, 10'd2, 10'd2, INS_PADD}, 1'b0, 1'b1);
    push_cmd({10'd3, 10'd3, 10'd3, INS_PSUB}, 1'b0, 1'b1);
    run = 1'b1;
    wait_state("rundrop_wait", S_WAIT, 20);
    run = 1'b0;
    wait_idle("rundrop_idle", 200);
    check("rundrop_retired", 64'(retired), 64'd22);
    repeat (10) @(negedge clk);
    #1;
    check("rundrop_fifo_cnt", 64'(fifo_cnt), 64'd2);
    check("rundrop_busy", 64'(busy), 64'd0);
    pulse_flush();
    check("rundrop_flush_cnt", 64'(fifo_cnt), 64'd0);

    // Asynchronous reset in WAIT
    model_lat = 50;
    push_cmd({10'd4, 10'd4, 10'd4, INS_AES_ENC}, 1'b0, 1'b1);
    exp_q.push_back({10'd4, 10'd4, 10'd4, INS_AES_ENC});
    push_cmd({10'd5, 10'd5, 10'd5, INS_AES_DEC}, 1'b0, 1'b1);
    run = 1'b1;
    wait_state("arst_wait", S_WAIT, 20);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_we0", 64'(bus.core_we0), 64'd0);
    check("arst_core_cmd", 64'(bus.core_cmd), 64'(NOP_CMD));
    check("arst_retired", 64'(retired), 64'd0);
    check("arst_tmo_err", 64'(tmo_err), 64'd0);
    check("arst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check("arst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("arst_state", 64'(state), 64'(S_IDLE));
    run = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    repeat (5) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule
